// File: rtl/imul_int_mul_var_param.sv
// Iterative integer multiplier with zero-skipping.
// Takes {mode, a, b} over a val/rdy request, works on operand magnitudes,
// retires up to MAX_SHIFT multiplier bits per cycle, fixes the sign at the
// end and returns the low or high half of the 2*NBITS product.
module imul_int_mul_var_param #(
    parameter int NBITS     = 32,
    parameter int MAX_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*NBITS+1:0]   req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [NBITS-1:0]     resp_msg
);

    localparam int SW = $clog2(MAX_SHIFT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*NBITS-1:0]   a_q, a_d;
    logic [NBITS-1:0]     b_q, b_d;
    logic [2*NBITS-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [1:0]           mode_q, mode_d;

    logic [1:0]           reqMode;
    logic [NBITS-1:0]     reqA;
    logic [NBITS-1:0]     reqB;
    logic                 aSigned;
    logic                 bSigned;
    logic                 aNeg;
    logic                 bNeg;
    logic [NBITS-1:0]     aAbs;
    logic [NBITS-1:0]     bAbs;
    logic [SW-1:0]        shamt;

    assign reqMode = req_msg[2*NBITS+1:2*NBITS];
    assign reqA    = req_msg[2*NBITS-1:NBITS];
    assign reqB    = req_msg[NBITS-1:0];

    // Operand magnitudes: only operands treated as signed in the mode are negated
    always_comb begin
        aSigned = reqMode[0];
        bSigned = (reqMode == 2'b01);
        aNeg    = aSigned & reqA[NBITS-1];
        bNeg    = bSigned & reqB[NBITS-1];
        aAbs    = aNeg ? (~reqA + 1'b1) : reqA;
        bAbs    = bNeg ? (~reqB + 1'b1) : reqB;
    end

    // Shift amount: one for the current bit plus the run of zeros above it, capped
    always_comb begin
        shamt = SW'(MAX_SHIFT);
        for (int i = MAX_SHIFT - 1; i >= 1; i--) begin
            if (b_q[i]) begin
                shamt = SW'(i);
            end
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        mode_d   = mode_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    a_d     = {{NBITS{1'b0}}, aAbs};
                    b_d     = bAbs;
                    acc_d   = '0;
                    mode_d  = reqMode;
                    neg_d   = aNeg ^ bNeg;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (b_q != '0) begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    b_d = b_q >> shamt;
                    a_d = a_q << shamt;
                end else begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (neg_q) begin
                    acc_d = ~acc_q + 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            mode_q  <= mode_d;
        end
    end

    assign resp_msg = (mode_q == 2'b00) ? acc_q[NBITS-1:0] : acc_q[2*NBITS-1:NBITS];

endmodule

// File: tb/tb_imul_int_mul_var_param.sv
// Self-checking bench for imul_int_mul_var_param with a scoreboard queue.
module tb_imul_int_mul_var_param;

    localparam int N  = 32;
    localparam int MS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_val;
    logic            req_rdy;
    logic [2*N+1:0]  req_msg;
    logic            resp_val;
    logic            resp_rdy;
    logic [N-1:0]    resp_msg;

    int testCount = 0;
    int failCount = 0;
    logic [N-1:0] expQ[$];

    imul_int_mul_var_param #(.NBITS(N), .MAX_SHIFT(MS)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result from sign/zero-extended full-width multiplication
    function automatic logic [N-1:0] model(input logic [1:0] mode, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] ax;
        logic [2*N-1:0] bx;
        logic [2*N-1:0] p;
        ax = mode[0]         ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        bx = (mode == 2'b01) ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
        p  = ax * bx;
        return (mode == 2'b00) ? p[N-1:0] : p[2*N-1:N];
    endfunction

    // Drive one request; returns #1 after the accepting edge
    task automatic applyStimulus(input logic [1:0] mode, input logic [N-1:0] a, input logic [N-1:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("req_rdy_timeout", 0, 1);
        req_val = 1'b1;
        req_msg = {mode, a, b};
        expQ.push_back(model(mode, a, b));
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    // Wait for the response, compare against the scoreboard and optionally the latency
    task automatic collectResponse(input string tag, input int expLat);
        int lat;
        logic [N-1:0] exp;
        lat = 1;
        while (!resp_val && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_val) begin
            checkOutput({tag, "_timeout"}, 0, 1);
        end else if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 1, 0);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, resp_msg, exp);
            if (expLat != 0) checkOutput({tag, "_lat"}, lat, expLat);
            if (resp_rdy) begin
                @(posedge clk);
                #1;
                checkOutput({tag, "_rdy_after"}, req_rdy, 1);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;

        #12;
        checkOutput("rst_req_rdy", req_rdy, 1);
        checkOutput("rst_resp_val", resp_val, 0);
        checkOutput("rst_resp_msg", resp_msg, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases with known latencies
        applyStimulus(2'b00, 32'd3, 32'd5);
        collectResponse("mul_3x5", 5);
        checkOutput("mul_3x5_val", model(2'b00, 32'd3, 32'd5), 32'h0000000F);
        applyStimulus(2'b00, 32'h1234, 32'd0);
        collectResponse("mul_b0", 3);
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collectResponse("mulh_m1", 0);
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collectResponse("mulhu_max", 35);
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collectResponse("mulhsu_m1", 0);
        applyStimulus(2'b00, 32'h80000000, 32'd2);
        collectResponse("mul_wrap", 0);
        applyStimulus(2'b01, 32'h80000000, 32'h80000000);
        collectResponse("mulh_min", 0);

        // Random operands across every mode
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'(i % 4), 32'($urandom), 32'($urandom));
            collectResponse("rand", 0);
        end

        // Backpressure: response must hold while resp_rdy is low
        resp_rdy = 1'b0;
        applyStimulus(2'b00, 32'd7, 32'd6);
        collectResponse("bp_mul", 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_val", resp_val, 1);
            checkOutput("bp_msg", resp_msg, 42);
            checkOutput("bp_req_rdy", req_rdy, 0);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_rdy_after", req_rdy, 1);
        checkOutput("bp_val_after", resp_val, 0);

        // Asynchronous reset during the second CALC cycle discards the operation
        applyStimulus(2'b00, 32'd5, 32'h0000FFFF);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_resp_val", resp_val, 0);
        checkOutput("arst_req_rdy", req_rdy, 1);
        checkOutput("arst_resp_msg", resp_msg, 0);
        expQ.delete();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(2'b00, 32'd2, 32'd2);
        collectResponse("post_rst", 0);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
